ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the shared PS2_CLK/PS2_DAT lines.
- It is the outbound counterpart of the existing PS/2 receive path and sits beside PS2_Controller in the keyboard top level.
- It drives the lines open-drain through output-enable signals. The top level ties each line as: line = oe ? 1'b0 : 1'bz.
- It reports success, or the reason for failure, back to the command sequencer.

Parameters:
- INHIBIT_CYCLES, 6000: clock-inhibit duration, 120 us at 50 MHz.
- START_TIMEOUT, 750000: maximum wait from clock release to the first device falling edge (15 ms).
- XFER_TIMEOUT, 100000: maximum time from the first falling edge to the ACK edge (2 ms).
- SYNC_STAGES, 2: synchroniser depth on ps2_clk_in and ps2_dat_in.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset_n  in  1  synchronous reset, active-low.
- send_cmd  in  1  single-cycle request. Sampled only in IDLE.
- cmd_data  in  8  byte to send. Latched when send_cmd is accepted.
- ps2_clk_in  in  1  raw PS2_CLK level.
- ps2_dat_in  in  1  raw PS2_DAT level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.
- busy  out  1  high from accept until return to IDLE. The receive path ignores data while busy.
- cmd_sent  out  1  one-cycle pulse on successful ACK followed by bus idle.
- error  out  1  one-cycle pulse on failure.
- err_code  out  2  00 none, 01 start timeout, 10 transfer timeout, 11 no ACK. Held until the next accepted send_cmd, which clears it to 00.

Behaviour:
- Reset (reset_n=0 at a CLOCK_50 edge):
  - FSM goes to IDLE.
  - All outputs are 0: clk_oe, dat_oe, busy, cmd_sent, error, err_code=00.
  - Synchroniser and edge-detect registers are set to 1.
  - Reset mid-transfer releases both lines on that same edge. Reset wins over a simultaneous send_cmd.
- Inputs pass through the SYNC_STAGES flop chain.
- fall = previous synchronised clock is 1 and current synchronised clock is 0.
- Shift data: {stop=1, parity, cmd_data[7:0]}, sent LSB first. parity = ~^cmd_data (odd parity).
- FSM states:
  - IDLE:
    - On send_cmd: latch data, clear err_code, set busy=1, go to INHIBIT next cycle.
    - send_cmd while busy is ignored; no queueing.
  - INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - REQ:
    - clk_oe=1 and dat_oe=1 (start bit) for exactly 1 cycle, then go to WAIT_FIRST.
    - Data is asserted before the clock is released.
  - WAIT_FIRST:
    - clk_oe=0, dat_oe=1, timeout counter runs.
    - On fall: present bit0 (dat_oe = ~bit0), bit index 1, go to SHIFT, start XFER counter.
    - If the counter reaches START_TIMEOUT before a fall: go to FAIL with code 01.
  - SHIFT:
    - On each fall: present the next bit, index+1.
    - Falls 2..8 present data bits 1..7; fall 9 presents parity; fall 10 presents stop (dat_oe=0).
    - After fall 10, go to ACK.
  - ACK:
    - On fall 11, sample synchronised dat.
    - dat=0: go to WAIT_IDLE.
    - dat=1: go to FAIL with code 11.
  - WAIT_IDLE:
    - Wait until synchronised clk=1 and dat=1 in the same cycle.
    - Then pulse cmd_sent for 1 cycle and go to IDLE; busy drops in the same cycle.
  - FAIL:
    - dat_oe=0 and clk_oe=0 on entry.
    - error pulses for 1 cycle, err_code is set, go to IDLE.
- XFER counter:
  - Runs in SHIFT, ACK and WAIT_IDLE.
  - Reaching XFER_TIMEOUT forces FAIL with code 10. This takes priority over a fall in the same cycle.
- Counters saturate at their terminal value and never wrap. Counter width is $clog2 of the largest parameter.
- Falls during IDLE or INHIBIT are ignored. In INHIBIT the host is holding the clock low, so no device edges occur.
- dat_oe changes only in the cycle after a detected fall. The device samples on the rising edge, so setup is met.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state encodings.
  - ERR_NONE/ERR_START/ERR_XFER/ERR_NOACK codes.
  - Command constants: CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, RSP_ACK=8'hFA.
- One sub-module, ps2_line_sync: SYNC_STAGES synchroniser plus falling-edge detect for the clock. It is reusable by the receive path.

Test Plan:
- Send 0xED to a device model that clocks at 12.5 kHz and ACKs:
  - clk_oe is high for exactly 6000 cycles, then REQ for 1 cycle.
  - Bits observed on device rising edges: 0, 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - cmd_sent pulses once; err_code=00.
- Send 0xF4 (five ones) -> parity bit observed = 0; cmd_sent pulses.
- Device never clocks -> error pulses exactly START_TIMEOUT cycles after clk_oe falls; err_code=01; both oe=0.
- Device clocks 11 edges but holds dat high at edge 11 -> err_code=11; no cmd_sent.
- Device stops clocking after 5 edges -> err_code=10 at XFER_TIMEOUT cycles after the first fall.
- Variants:
  - Assert reset_n=0 during SHIFT -> next edge shows clk_oe=dat_oe=busy=0.
  - Pulse send_cmd with 0x00 while busy -> ignored; the original byte completes.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, error codes and the
// keyboard command bytes used by the command sequencer.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_WAIT_FIRST,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_FAIL
  } ps2_tx_state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_START = 2'b01;
  localparam logic [1:0] ERR_XFER  = 2'b10;
  localparam logic [1:0] ERR_NOACK = 2'b11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the raw PS2_CLK/PS2_DAT levels into the CLOCK_50 domain and
// flags device falling clock edges; shared with the receive path.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [SYNC_STAGES-1:0] clk_chain;
  logic [SYNC_STAGES-1:0] dat_chain;
  logic                   clk_prev;

  // Idle bus level is high, so every stage resets to 1 to avoid a false edge
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      clk_chain <= '1;
      dat_chain <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_chain <= {clk_chain[SYNC_STAGES-2:0], ps2_clk_in};
      dat_chain <= {dat_chain[SYNC_STAGES-2:0], ps2_dat_in};
      clk_prev  <= clk_chain[SYNC_STAGES-1];
    end
  end

  assign clk_sync = clk_chain[SYNC_STAGES-1];
  assign dat_sync = dat_chain[SYNC_STAGES-1];
  assign clk_fall = clk_prev & ~clk_chain[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte out on device clock edges and checks the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       send_cmd,
  input  logic [7:0] cmd_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       cmd_sent,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int CNT_TOP = (MAX_AB > XFER_TIMEOUT) ? MAX_AB : XFER_TIMEOUT;
  localparam int CW      = $clog2(CNT_TOP);

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT - 1);

  logic clk_sync, dat_sync, clk_fall;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .clk_sync  (clk_sync),
    .dat_sync  (dat_sync),
    .clk_fall  (clk_fall)
  );

  ps2_tx_state_t state, state_next;
  logic [CW-1:0] cnt;
  logic          cnt_clear;
  logic [9:0]    shift_reg, shift_next;
  logic [3:0]    bit_idx, idx_next;
  logic          clk_oe_next, dat_oe_next, busy_next, cmd_sent_next, error_next;
  logic [1:0]    err_code_next;
  logic          fail_now;
  logic [1:0]    fail_code;

  // All line drivers and status flags are registered so the open-drain
  // enables never glitch and a reset releases the bus on the same edge
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shift_reg  <= '1;
      bit_idx    <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      cmd_sent   <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_idx    <= idx_next;
      ps2_clk_oe <= clk_oe_next;
      ps2_dat_oe <= dat_oe_next;
      busy       <= busy_next;
      cmd_sent   <= cmd_sent_next;
      error      <= error_next;
      err_code   <= err_code_next;
      if (cnt_clear)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  // One counter serves inhibit, start timeout and the whole-transfer timeout;
  // it is only cleared on entry to INHIBIT, WAIT_FIRST and SHIFT
  always_comb begin
    state_next    = state;
    cnt_clear     = 1'b0;
    shift_next    = shift_reg;
    idx_next      = bit_idx;
    clk_oe_next   = ps2_clk_oe;
    dat_oe_next   = ps2_dat_oe;
    busy_next     = busy;
    cmd_sent_next = 1'b0;
    error_next    = 1'b0;
    err_code_next = err_code;
    fail_now      = 1'b0;
    fail_code     = ERR_NONE;

    case (state)
      ST_IDLE: begin
        clk_oe_next = 1'b0;
        dat_oe_next = 1'b0;
        busy_next   = 1'b0;
        if (send_cmd) begin
          state_next    = ST_INHIBIT;
          shift_next    = {1'b1, odd_parity(cmd_data), cmd_data};
          err_code_next = ERR_NONE;
          busy_next     = 1'b1;
          clk_oe_next   = 1'b1;
          cnt_clear     = 1'b1;
        end
      end
      ST_INHIBIT: begin
        if (cnt == INH_LAST) begin
          state_next  = ST_REQ;
          dat_oe_next = 1'b1;
        end
      end
      ST_REQ: begin
        state_next  = ST_WAIT_FIRST;
        clk_oe_next = 1'b0;
        cnt_clear   = 1'b1;
      end
      ST_WAIT_FIRST: begin
        if (clk_fall) begin
          state_next  = ST_SHIFT;
          dat_oe_next = ~shift_reg[0];
          idx_next    = 4'd1;
          cnt_clear   = 1'b1;
        end else if (cnt == START_LAST) begin
          fail_now  = 1'b1;
          fail_code = ERR_START;
        end
      end
      ST_SHIFT: begin
        if (cnt == XFER_LAST) begin
          fail_now  = 1'b1;
          fail_code = ERR_XFER;
        end else if (clk_fall) begin
          dat_oe_next = ~shift_reg[bit_idx];
          idx_next    = bit_idx + 4'd1;
          if (bit_idx == 4'd9)
            state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        if (cnt == XFER_LAST) begin
          fail_now  = 1'b1;
          fail_code = ERR_XFER;
        end else if (clk_fall) begin
          if (!dat_sync) begin
            state_next = ST_WAIT_IDLE;
          end else begin
            fail_now  = 1'b1;
            fail_code = ERR_NOACK;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (cnt == XFER_LAST) begin
          fail_now  = 1'b1;
          fail_code = ERR_XFER;
        end else if (clk_sync && dat_sync) begin
          state_next    = ST_IDLE;
          cmd_sent_next = 1'b1;
          busy_next     = 1'b0;
        end
      end
      ST_FAIL: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
      default: state_next = ST_IDLE;
    endcase

    // Failure releases both lines immediately and reports on entry to FAIL
    if (fail_now) begin
      state_next    = ST_FAIL;
      clk_oe_next   = 1'b0;
      dat_oe_next   = 1'b0;
      error_next    = 1'b1;
      err_code_next = fail_code;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device model driving
// the open-drain lines; timeouts are scaled down to keep runs short.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH      = 40;
  localparam int START_TO = 300;
  localparam int XFER_TO  = 600;
  localparam int HALF     = 10;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       send_cmd = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       dev_clk  = 1'b1;
  logic       dev_dat  = 1'b1;
  logic       ps2_clk_oe, ps2_dat_oe, busy, cmd_sent, error;
  logic [1:0] err_code;
  logic       ps2_clk_line, ps2_dat_line;

  int checks = 0;
  int errors = 0;

  int   cyc_n = 0, sent_cnt = 0, err_cnt = 0, datoe_fall_cyc = 0, err_cyc = 0;
  logic dat_oe_q = 1'b0;

  assign ps2_clk_line = ps2_clk_oe ? 1'b0 : dev_clk;
  assign ps2_dat_line = ps2_dat_oe ? 1'b0 : dev_dat;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (START_TO),
    .XFER_TIMEOUT  (XFER_TO),
    .SYNC_STAGES   (2)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .send_cmd  (send_cmd),
    .cmd_data  (cmd_data),
    .ps2_clk_in(ps2_clk_line),
    .ps2_dat_in(ps2_dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .cmd_sent  (cmd_sent),
    .error     (error),
    .err_code  (err_code)
  );

  // Pulse and edge monitor sampled away from the active edge
  always @(negedge CLOCK_50) begin
    cyc_n = cyc_n + 1;
    if (dat_oe_q && !ps2_dat_oe) datoe_fall_cyc = cyc_n;
    dat_oe_q = ps2_dat_oe;
    if (error) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc_n;
    end
    if (cmd_sent) sent_cnt = sent_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    @(negedge CLOCK_50);
    send_cmd = 1'b1;
    cmd_data = data;
    @(negedge CLOCK_50);
    send_cmd = 1'b0;
  endtask

  task automatic waitWaitFirst();
    int n = 0;
    while (!(!ps2_clk_oe && ps2_dat_oe) && n < INH + 20) begin
      @(negedge CLOCK_50);
      n++;
    end
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge CLOCK_50);
      n++;
    end
    waitCycles(5);
  endtask

  // Device: samples the start bit before its first fall, then one bit per
  // rising edge; on fall 11 it drives the ACK level chosen by ack_low
  task automatic deviceXfer(input int falls, input logic ack_low, output logic [10:0] obs);
    obs = '0;
    waitCycles(HALF);
    obs[0] = ps2_dat_line;
    for (int k = 1; k <= falls; k++) begin
      if (k == 11) begin
        dev_dat = !ack_low;
        waitCycles(3);
      end
      dev_clk = 1'b0;
      waitCycles(HALF);
      if (k <= 10) obs[k] = ps2_dat_line;
      dev_clk = 1'b1;
      waitCycles(HALF);
    end
    dev_dat = 1'b1;
  endtask

  initial begin
    int n, m, s0, e0;
    logic [10:0] obs;

    // Reset state
    reset_n = 1'b0;
    waitCycles(3);
    checkOutput("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    checkOutput("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cmd_sent", 32'(cmd_sent), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_err_code", 32'(err_code), 32'd0);
    reset_n = 1'b1;
    waitCycles(2);

    // 0xED: inhibit length, request, bit stream, ACK
    $display("[TB] send 0xED with ACK");
    s0 = sent_cnt; e0 = err_cnt;
    applyStimulus(CMD_SET_LEDS);
    checkOutput("ed_busy", 32'(busy), 32'd1);
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < INH + 10) begin
      n++;
      @(negedge CLOCK_50);
    end
    checkOutput("ed_inhibit_len", 32'(n), 32'(INH));
    m = 0;
    while (ps2_clk_oe && ps2_dat_oe && m < 5) begin
      m++;
      @(negedge CLOCK_50);
    end
    checkOutput("ed_req_len", 32'(m), 32'd1);
    deviceXfer(11, 1'b1, obs);
    waitIdle(100);
    checkOutput("ed_bits", 32'(obs), 32'b1_1_11101101_0);
    checkOutput("ed_sent", 32'(sent_cnt - s0), 32'd1);
    checkOutput("ed_no_error", 32'(err_cnt - e0), 32'd0);
    checkOutput("ed_err_code", 32'(err_code), 32'(ERR_NONE));
    checkOutput("ed_busy_done", 32'(busy), 32'd0);

    // 0xF4: parity bit must be 0
    $display("[TB] send 0xF4 with ACK");
    s0 = sent_cnt;
    applyStimulus(CMD_ENABLE);
    waitWaitFirst();
    deviceXfer(11, 1'b1, obs);
    waitIdle(100);
    checkOutput("f4_parity", 32'(obs[9]), 32'd0);
    checkOutput("f4_bits", 32'(obs), 32'b1_0_11110100_0);
    checkOutput("f4_sent", 32'(sent_cnt - s0), 32'd1);

    // Device never clocks: start timeout
    $display("[TB] start timeout");
    applyStimulus(CMD_ENABLE);
    waitWaitFirst();
    n = 0;
    while (!error && n < START_TO + 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    checkOutput("start_to_delay", 32'(n), 32'(START_TO));
    checkOutput("start_to_code", 32'(err_code), 32'(ERR_START));
    checkOutput("start_to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    checkOutput("start_to_dat_oe", 32'(ps2_dat_oe), 32'd0);
    @(negedge CLOCK_50);
    checkOutput("start_to_pulse", 32'(error), 32'd0);
    waitIdle(20);
    checkOutput("start_to_idle", 32'(busy), 32'd0);

    // Data held high at the ACK edge
    $display("[TB] missing ACK");
    s0 = sent_cnt; e0 = err_cnt;
    applyStimulus(CMD_SET_LEDS);
    waitWaitFirst();
    deviceXfer(11, 1'b0, obs);
    waitIdle(100);
    checkOutput("noack_code", 32'(err_code), 32'(ERR_NOACK));
    checkOutput("noack_sent", 32'(sent_cnt - s0), 32'd0);
    checkOutput("noack_error", 32'(err_cnt - e0), 32'd1);

    // Device stops after five edges: transfer timeout from the first fall
    $display("[TB] transfer timeout");
    applyStimulus(CMD_RESET);
    checkOutput("xfer_code_cleared", 32'(err_code), 32'(ERR_NONE));
    waitWaitFirst();
    deviceXfer(5, 1'b1, obs);
    waitIdle(XFER_TO + 100);
    checkOutput("xfer_to_delay", 32'(err_cyc - datoe_fall_cyc), 32'(XFER_TO));
    checkOutput("xfer_to_code", 32'(err_code), 32'(ERR_XFER));

    // Reset during SHIFT releases the bus on the next edge
    $display("[TB] reset mid-transfer");
    applyStimulus(8'h00);
    waitWaitFirst();
    deviceXfer(3, 1'b1, obs);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    checkOutput("mid_dat_oe", 32'(ps2_dat_oe), 32'd1);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    checkOutput("mid_rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    waitCycles(5);

    // send_cmd while busy is ignored; original byte completes
    $display("[TB] send while busy");
    s0 = sent_cnt;
    applyStimulus(CMD_SET_LEDS);
    applyStimulus(8'h00);
    waitWaitFirst();
    applyStimulus(8'h00);
    deviceXfer(11, 1'b1, obs);
    waitIdle(100);
    checkOutput("busy_ign_bits", 32'(obs), 32'b1_1_11101101_0);
    checkOutput("busy_ign_sent", 32'(sent_cnt - s0), 32'd1);
    checkOutput("busy_ign_code", 32'(err_code), 32'(ERR_NONE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
